// File: rtl/add_image_wd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_image_wd_pkg
//  Description : Shared state encoding and default sizing for the add_image
//                deadlock watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_image_wd_pkg;

    // Watchdog state encoding; values are visible on the wd_state port
    typedef enum logic [2:0] {
        WD_DISABLED = 3'd0,
        WD_ARMED    = 3'd1,
        WD_SUSPECT  = 3'd2,
        WD_REPORT   = 3'd3,
        WD_RECOVER  = 3'd4,
        WD_HOLDOFF  = 3'd5
    } wd_state_t;

    localparam int DEF_N_PROC = 5;
    localparam int DEF_N_AXIS = 5;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_EVT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/add_image_wd_stall_detect.sv
`default_nettype none
// ============================================================================
//  Module      : add_image_wd_stall_detect
//  Description : Reduces per-process idle/blocked status to a single stall
//                flag (every process stuck, at least one on AXIS) and
//                registers it once.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_image_wd_stall_detect
    import add_image_wd_pkg::*;
#(
    parameter int N_PROC = DEF_N_PROC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PROC-1:0] proc_idle,
    input  logic [N_PROC-1:0] proc_chan_block,
    input  logic [N_PROC-1:0] proc_axis_block,
    output logic              stall_q
);

    logic stall_d;

    // Stall only when no process can make progress and AXIS is involved
    always_comb begin
        stall_d = (&(proc_idle | proc_chan_block | proc_axis_block)) & (|proc_axis_block);
    end

    // One register stage between raw status and the watchdog FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_image_deadlock_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : add_image_deadlock_watchdog
//  Description : Qualifies persistent dataflow deadlocks, latches a status
//                snapshot, raises a sticky interrupt and optionally runs a
//                recovery handshake followed by a holdoff window.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_image_deadlock_watchdog
    import add_image_wd_pkg::*;
#(
    parameter int N_PROC = DEF_N_PROC,
    parameter int N_AXIS = DEF_N_AXIS,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int EVT_W  = DEF_EVT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              auto_recover,
    input  logic [CNT_W-1:0]  threshold,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic [N_PROC-1:0] proc_idle,
    input  logic [N_PROC-1:0] proc_chan_block,
    input  logic [N_PROC-1:0] proc_axis_block,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic              irq_ack,
    input  logic              recover_done,
    output logic              irq,
    output logic              recover_req,
    output logic [2:0]        wd_state,
    output logic [N_PROC-1:0] snap_idle,
    output logic [N_PROC-1:0] snap_chan,
    output logic [N_PROC-1:0] snap_axis,
    output logic [N_AXIS-1:0] snap_axis_sigs,
    output logic [EVT_W-1:0]  evt_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

    wd_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               recover_req_q, recover_req_d;
    logic [EVT_W-1:0]   evt_q, evt_d;
    logic [N_PROC-1:0]  snap_idle_q, snap_idle_d;
    logic [N_PROC-1:0]  snap_chan_q, snap_chan_d;
    logic [N_PROC-1:0]  snap_axis_q, snap_axis_d;
    logic [N_AXIS-1:0]  snap_sigs_q, snap_sigs_d;

    logic               stall_q;
    logic               qualify;
    logic [CNT_W-1:0]   thr_eff;
    logic [CNT_W-1:0]   cnt_inc;

    add_image_wd_stall_detect #(
        .N_PROC (N_PROC)
    ) u_stall_detect (
        .clock           (clock),
        .reset           (reset),
        .proc_idle       (proc_idle),
        .proc_chan_block (proc_chan_block),
        .proc_axis_block (proc_axis_block),
        .stall_q         (stall_q)
    );

    // Next-state, counter, interrupt and snapshot logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irq_d       = irq_q;
        evt_d       = evt_q;
        snap_idle_d = snap_idle_q;
        snap_chan_d = snap_chan_q;
        snap_axis_d = snap_axis_q;
        snap_sigs_d = snap_sigs_q;
        qualify     = 1'b0;

        thr_eff = (threshold == '0) ? CNT_ONE : threshold;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

        // Ack clears irq anywhere; a simultaneous qualification re-sets it below
        if (irq_ack) begin
            irq_d = 1'b0;
        end

        if (!enable) begin
            state_d = WD_DISABLED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                WD_DISABLED: begin
                    state_d = WD_ARMED;
                    cnt_d   = '0;
                end
                WD_ARMED: begin
                    cnt_d = '0;
                    if (stall_q) begin
                        if (thr_eff == CNT_ONE) begin
                            qualify = 1'b1;
                        end else begin
                            state_d = WD_SUSPECT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                WD_SUSPECT: begin
                    // >= so a threshold lowered below the count qualifies at once
                    if (!stall_q) begin
                        state_d = WD_ARMED;
                        cnt_d   = '0;
                    end else if (cnt_inc >= thr_eff) begin
                        qualify = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WD_REPORT: begin
                    cnt_d = '0;
                    if (irq_ack) begin
                        state_d = auto_recover ? WD_RECOVER : WD_ARMED;
                    end
                end
                WD_RECOVER: begin
                    if (recover_done) begin
                        state_d = WD_HOLDOFF;
                        cnt_d   = '0;
                    end
                end
                WD_HOLDOFF: begin
                    // Stall is ignored here; at least one cycle is spent
                    if (cnt_inc >= holdoff) begin
                        state_d = WD_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = WD_DISABLED;
                    cnt_d   = '0;
                end
            endcase
        end

        if (qualify) begin
            state_d     = WD_REPORT;
            cnt_d       = '0;
            irq_d       = 1'b1;
            evt_d       = (evt_q == '1) ? evt_q : evt_q + EVT_ONE;
            snap_idle_d = proc_idle;
            snap_chan_d = proc_chan_block;
            snap_axis_d = proc_axis_block;
            snap_sigs_d = axis_block_sigs;
        end

        recover_req_d = (state_d == WD_RECOVER);
    end

    // State, counter and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= WD_DISABLED;
            cnt_q         <= '0;
            irq_q         <= 1'b0;
            recover_req_q <= 1'b0;
            evt_q         <= '0;
            snap_idle_q   <= '0;
            snap_chan_q   <= '0;
            snap_axis_q   <= '0;
            snap_sigs_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            irq_q         <= irq_d;
            recover_req_q <= recover_req_d;
            evt_q         <= evt_d;
            snap_idle_q   <= snap_idle_d;
            snap_chan_q   <= snap_chan_d;
            snap_axis_q   <= snap_axis_d;
            snap_sigs_q   <= snap_sigs_d;
        end
    end

    assign irq            = irq_q;
    assign recover_req    = recover_req_q;
    assign wd_state       = state_q;
    assign snap_idle      = snap_idle_q;
    assign snap_chan      = snap_chan_q;
    assign snap_axis      = snap_axis_q;
    assign snap_axis_sigs = snap_sigs_q;
    assign evt_count      = evt_q;

endmodule
`default_nettype wire
